spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 22 ++
 rtl/spi_slave.sv | 145 ++++++++++++++
 tb/tb_spi_slave.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI pin bundle between an SPI master and the spi_slave block.
// The master drives CS/SCLK/MOSI; the slave drives MISO.
interface spi_slave_if;
    logic spi_cs;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_cs,
        output spi_clk,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_cs,
        input  spi_clk,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, MSB first, oversampled by clk with 2-FF synchronizers.
// Define SPI_SLAVE_ABORT_FLAG_EN to add the 'abort' mid-word CS-release pulse.
module spi_slave #(
    parameter int Nd = 3,
    parameter int Nc = 6
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_if.slave        spi,
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    output logic              abort,
`endif
    input  logic [2**Nd-1:0]  data_in,
    output logic [2**Nd-1:0]  data_out,
    output logic              data_rdy,
    output logic [Nc-1:0]     cyc_num,
    output logic              busy
);
    localparam int N = 2**Nd;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_cs_s;
    logic [2:0]     r_sck_s;
    logic [1:0]     r_mosi_s;
    logic [N-1:0]   r_rx;
    logic [N-1:0]   r_tx;
    logic [Nd-1:0]  r_bitcnt;
    logic [Nc-1:0]  r_cyc;
    logic [N-1:0]   r_data_out;
    logic           r_data_rdy;
    logic           r_miso;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    logic           r_abort;
`endif

    logic           w_act;
    logic           w_start;
    logic           w_end;
    logic           w_sck_rise;
    logic           w_sck_fall;
    logic           w_rise;
    logic           w_done;
    logic [Nd-1:0]  w_bit_nxt;
    logic [N-1:0]   w_rx_nxt;

    // Edges are taken between the 2nd sync stage and the 3rd copy
    assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
    assign w_act      = (r_state == ACTIVE);
    assign w_start    = (r_state == IDLE) & ~r_cs_s[1] & r_cs_s[2];
    assign w_end      = w_act & r_cs_s[1];
    assign w_rise     = w_act & w_sck_rise;
    assign w_done     = w_rise & (&r_bitcnt);
    assign w_bit_nxt  = r_bitcnt + Nd'(w_rise);
    assign w_rx_nxt   = {r_rx[N-2:0], r_mosi_s[1]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                busy = 1'b1;
                if (r_cs_s[1]) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_s     <= 3'b111;
            r_sck_s    <= '0;
            r_mosi_s   <= '0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_bitcnt   <= '0;
            r_cyc      <= '0;
            r_data_out <= '0;
            r_data_rdy <= 1'b0;
            r_miso     <= 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
            r_abort    <= 1'b0;
`endif
        end else begin
            r_cs_s     <= {r_cs_s[1:0], spi.spi_cs};
            r_sck_s    <= {r_sck_s[1:0], spi.spi_clk};
            r_mosi_s   <= {r_mosi_s[0], spi.spi_mosi};
            r_data_rdy <= 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
            r_abort    <= 1'b0;
`endif
            if (w_start) begin
                r_miso   <= data_in[N-1];
                r_tx     <= data_in << 1;
                r_rx     <= '0;
                r_bitcnt <= '0;
                r_cyc    <= '0;
            end else if (w_act) begin
                if (w_rise) begin
                    r_rx     <= w_rx_nxt;
                    r_bitcnt <= w_bit_nxt;
                end
                if (w_done) begin
                    r_data_out <= w_rx_nxt;
                    r_data_rdy <= 1'b1;
                    r_cyc      <= r_cyc + 1'b1;
                end
                // CS release still honours an edge seen on the same clk
                if (w_end) begin
                    r_miso   <= 1'b0;
                    r_tx     <= '0;
                    r_bitcnt <= '0;
                    if (!w_done) r_cyc <= '0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
                    r_abort  <= (w_bit_nxt != '0);
`endif
                end else if (r_data_rdy) begin
                    r_tx <= data_in;
                end else if (w_sck_fall) begin
                    r_miso <= r_tx[N-1];
                    r_tx   <= r_tx << 1;
                end
            end
        end
    end

    assign spi.spi_miso = r_miso;
    assign data_out     = r_data_out;
    assign data_rdy     = r_data_rdy;
    assign cyc_num      = r_cyc;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    assign abort        = r_abort;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master task drives words and
// a negedge monitor logs data_rdy events; a second Nc=2 copy checks wrap.
module tb_spi_slave;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out, data_out2;
    logic        data_rdy, data_rdy2;
    logic [5:0]  cyc_num;
    logic [1:0]  cyc_num2;
    logic        busy, busy2;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    logic        abort, abort2;
    int          n_abort = 0;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rdy = 0;
    int          k_din = 0;
    logic [7:0]  din_idle = 8'h00;
    logic [7:0]  din_next [0:3];
    logic [31:0] q_do[$];
    logic [31:0] q_cyc[$];
    logic [31:0] q_cyc2[$];

    always #5 clk = ~clk;

    spi_slave_if sif();
    spi_slave_if sif2();

    assign sif2.spi_cs   = sif.spi_cs;
    assign sif2.spi_clk  = sif.spi_clk;
    assign sif2.spi_mosi = sif.spi_mosi;

    spi_slave #(.Nd(3), .Nc(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi      (sif),
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        .abort    (abort),
`endif
        .data_in  (data_in),
        .data_out (data_out),
        .data_rdy (data_rdy),
        .cyc_num  (cyc_num),
        .busy     (busy)
    );

    spi_slave #(.Nd(3), .Nc(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .spi      (sif2),
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        .abort    (abort2),
`endif
        .data_in  (data_in),
        .data_out (data_out2),
        .data_rdy (data_rdy2),
        .cyc_num  (cyc_num2),
        .busy     (busy2)
    );

    // Next transmit word is presented right after each data_rdy
    always @(negedge clk) begin
        if (!busy) begin
            data_in = din_idle;
            k_din   = 0;
        end else if (data_rdy) begin
            if (k_din < 4) data_in = din_next[k_din];
            k_din = k_din + 1;
        end
        if (data_rdy) begin
            n_rdy = n_rdy + 1;
            q_do.push_back(32'(data_out));
            q_cyc.push_back(32'(cyc_num));
        end
        if (data_rdy2) q_cyc2.push_back(32'(cyc_num2));
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        if (abort && abort2) n_abort = n_abort + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic cs_lo();
        @(negedge clk);
        sif.spi_cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (H) @(negedge clk);
        sif.spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] w, input int nb,
                        output logic [7:0] mo);
        mo = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            @(negedge clk);
            sif.spi_mosi = w[i];
            repeat (H) @(negedge clk);
            mo[i] = sif.spi_miso;
            sif.spi_clk = 1'b1;
            repeat (H) @(negedge clk);
            sif.spi_clk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] mo, mo1, mo2;
        int b, b2, r0;
        logic seen;
        sif.spi_cs   = 1'b1;
        sif.spi_clk  = 1'b0;
        sif.spi_mosi = 1'b0;
        for (int i = 0; i < 4; i++) din_next[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_rdy", 32'(data_rdy), 32'h0);
        check("rst_cyc_num", 32'(cyc_num), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_miso", 32'(sif.spi_miso), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single word 0xA5 in, 0x3C out
        din_idle = 8'h3C;
        b = q_do.size();
        r0 = n_rdy;
        cs_lo();
        check("s1_busy", 32'(busy), 32'h1);
        xfer(8'hA5, 8, mo);
        check("s1_miso", 32'(mo), 32'h3C);
        check("s1_nrdy", 32'(n_rdy - r0), 32'h1);
        check("s1_dout", qget(q_do, b), 32'hA5);
        check("s1_cyc", qget(q_cyc, b), 32'h1);
        check("s1_cyc_live", 32'(cyc_num), 32'h1);
        cs_hi();
        check("s1_busy_off", 32'(busy), 32'h0);

        // Three words in one CS, data_in refreshed after each data_rdy
        din_idle = 8'h11;
        din_next[0] = 8'h22;
        din_next[1] = 8'h33;
        b = q_do.size();
        r0 = n_rdy;
        cs_lo();
        xfer(8'h01, 8, mo);
        xfer(8'h80, 8, mo1);
        xfer(8'hFF, 8, mo2);
        check("s2_miso0", 32'(mo), 32'h11);
        check("s2_miso1", 32'(mo1), 32'h22);
        check("s2_miso2", 32'(mo2), 32'h33);
        check("s2_nrdy", 32'(n_rdy - r0), 32'h3);
        check("s2_dout0", qget(q_do, b), 32'h01);
        check("s2_dout1", qget(q_do, b + 1), 32'h80);
        check("s2_dout2", qget(q_do, b + 2), 32'hFF);
        check("s2_cyc0", qget(q_cyc, b), 32'h1);
        check("s2_cyc1", qget(q_cyc, b + 1), 32'h2);
        check("s2_cyc2", qget(q_cyc, b + 2), 32'h3);
        cs_hi();
        din_next[0] = 8'h00;
        din_next[1] = 8'h00;

        // CS released after 5 bits
        din_idle = 8'h00;
        r0 = n_rdy;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        b2 = n_abort;
`endif
        cs_lo();
        xfer(8'hB7, 5, mo);
        cs_hi();
        check("s3_nrdy", 32'(n_rdy - r0), 32'h0);
        check("s3_dout", 32'(data_out), 32'hFF);
        check("s3_busy", 32'(busy), 32'h0);
        check("s3_cyc", 32'(cyc_num), 32'h0);
        check("s3_miso", 32'(sif.spi_miso), 32'h0);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        check("s3_abort", 32'(n_abort - b2), 32'h1);
`endif

        // Five words: 6-bit counter counts on, 2-bit counter wraps
        b = q_cyc.size();
        b2 = q_cyc2.size();
        cs_lo();
        for (int i = 0; i < 5; i++) xfer(8'h10 + 8'(i), 8, mo);
        check("s4_cyc2_0", qget(q_cyc2, b2), 32'h1);
        check("s4_cyc2_1", qget(q_cyc2, b2 + 1), 32'h2);
        check("s4_cyc2_2", qget(q_cyc2, b2 + 2), 32'h3);
        check("s4_cyc2_3", qget(q_cyc2, b2 + 3), 32'h0);
        check("s4_cyc2_4", qget(q_cyc2, b2 + 4), 32'h1);
        check("s4_cyc_4", qget(q_cyc, b + 4), 32'h5);
        check("s4_dout2", 32'(data_out2), 32'h14);
        check("s4_busy2", 32'(busy2), 32'h1);
        cs_hi();

        // Reset mid-word, then a clean transaction
        cs_lo();
        xfer(8'hC3, 4, mo);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s5_rst_dout", 32'(data_out), 32'h0);
        check("s5_rst_rdy", 32'(data_rdy), 32'h0);
        check("s5_rst_cyc", 32'(cyc_num), 32'h0);
        check("s5_rst_busy", 32'(busy), 32'h0);
        check("s5_rst_miso", 32'(sif.spi_miso), 32'h0);
        sif.spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("s5_idle_busy", 32'(busy), 32'h0);
        r0 = n_rdy;
        cs_lo();
        xfer(8'h5A, 8, mo);
        check("s5_nrdy", 32'(n_rdy - r0), 32'h1);
        check("s5_dout", 32'(data_out), 32'h5A);
        cs_hi();

        // SCLK activity with CS high is ignored
        r0 = n_rdy;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sif.spi_mosi = 1'b1;
            sif.spi_clk = ~sif.spi_clk;
            repeat (H) @(negedge clk);
            seen = seen | sif.spi_miso | busy;
        end
        check("s6_nrdy", 32'(n_rdy - r0), 32'h0);
        check("s6_miso_busy", 32'(seen), 32'h0);
        check("s6_dout", 32'(data_out), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
